piezo_arb: RTL and testbench

- Owns the single piezo transducer and shares it among three requesters by fixed priority:
  - collision buzz from the command processor (highest);
  - battery-low chirp;
  - command-complete fanfare (lowest).
- Sequences tone frequency and duration per source and drives the differential piezo pins.
- Sits between cmd_proc, the battery monitor and the top-level piezo outputs.

---
 rtl/piezo_pkg.sv | 46 ++++
 rtl/piezo_tone.sv | 33 +++
 rtl/piezo_arb.sv | 112 +++++++++++
 tb/tb_piezo_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo arbiter.
package piezo_pkg;

    localparam int unsigned HP_W  = 15;
    localparam int unsigned DUR_W = 25;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLL     = 3'd1,
        BATT_ON  = 3'd2,
        BATT_OFF = 3'd3,
        FAN1     = 3'd4,
        FAN2     = 3'd5,
        FAN3     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_COLL = 2'd1,
        SRC_BATT = 2'd2,
        SRC_FAN  = 2'd3
    } src_t;

    // Tone half-periods in 50 MHz clocks
    localparam logic [HP_W-1:0] HP_COLL = 15'd12500;
    localparam logic [HP_W-1:0] HP_BATT = 15'd25000;
    localparam logic [HP_W-1:0] HP_FAN1 = 15'd15944;
    localparam logic [HP_W-1:0] HP_FAN2 = 15'd11945;
    localparam logic [HP_W-1:0] HP_FAN3 = 15'd9480;

    // Duration exponents: state lasts 2^exp clocks
    localparam int unsigned FAN_EXP_REAL  = 23;
    localparam int unsigned FAN_EXP_SIM   = 12;
    localparam int unsigned BON_EXP_REAL  = 22;
    localparam int unsigned BON_EXP_SIM   = 11;
    localparam int unsigned BOFF_EXP_REAL = 24;
    localparam int unsigned BOFF_EXP_SIM  = 13;

    // Terminal timer count for a 2^exp duration
    function automatic logic [DUR_W-1:0] dur_last(input int unsigned exp);
        logic [DUR_W-1:0] one;
        one = DUR_W'(1);
        return (one << exp) - one;
    endfunction

endpackage

// File: rtl/piezo_tone.sv
// Square-wave generator: half-period counter plus output flop.
module piezo_tone
    import piezo_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            restart,
    input  logic            en,
    input  logic [HP_W-1:0] half_per,
    output logic            sq
);

    logic [HP_W-1:0] cnt;

    // Restart forces a high first half-cycle; otherwise toggle every half_per clocks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (restart) begin
            cnt <= '0;
            sq  <= 1'b1;
        end else if (en) begin
            if (cnt == half_per - HP_W'(1)) begin
                cnt <= '0;
                sq  <= ~sq;
            end else begin
                cnt <= cnt + HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/piezo_arb.sv
// Fixed-priority owner of the piezo: collision > battery chirp > fanfare.
module piezo_arb
    import piezo_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buzz,
    input  logic       batt_low,
    input  logic       fanfare_req,
    output logic       piezo,
    output logic       piezo_n,
    output logic       busy,
    output logic [1:0] src
);

    localparam logic [DUR_W-1:0] FAN_LAST  = dur_last(FAST_SIM ? FAN_EXP_SIM  : FAN_EXP_REAL);
    localparam logic [DUR_W-1:0] BON_LAST  = dur_last(FAST_SIM ? BON_EXP_SIM  : BON_EXP_REAL);
    localparam logic [DUR_W-1:0] BOFF_LAST = dur_last(FAST_SIM ? BOFF_EXP_SIM : BOFF_EXP_REAL);

    state_t            state;
    state_t            nxt;
    logic [DUR_W-1:0]  dur_cnt;
    logic [DUR_W-1:0]  dur_lim;
    logic              dur_end;
    logic              fan_pend;
    logic              in_fan;
    logic              tone_active;
    logic [HP_W-1:0]   half_per;
    src_t              src_e;
    logic              sq;
    logic              state_chg;

    // Per-state decode of tone pitch, duration limit and source
    always_comb begin
        tone_active = 1'b0;
        half_per    = '0;
        dur_lim     = '0;
        src_e       = SRC_NONE;
        in_fan      = 1'b0;
        case (state)
            COLL:     begin tone_active = 1'b1; half_per = HP_COLL; src_e = SRC_COLL; end
            BATT_ON:  begin tone_active = 1'b1; half_per = HP_BATT; dur_lim = BON_LAST;  src_e = SRC_BATT; end
            BATT_OFF: begin dur_lim = BOFF_LAST; src_e = SRC_BATT; end
            FAN1:     begin tone_active = 1'b1; half_per = HP_FAN1; dur_lim = FAN_LAST; src_e = SRC_FAN; in_fan = 1'b1; end
            FAN2:     begin tone_active = 1'b1; half_per = HP_FAN2; dur_lim = FAN_LAST; src_e = SRC_FAN; in_fan = 1'b1; end
            FAN3:     begin tone_active = 1'b1; half_per = HP_FAN3; dur_lim = FAN_LAST; src_e = SRC_FAN; in_fan = 1'b1; end
            default:  ;
        endcase
    end

    assign dur_end   = (dur_cnt == dur_lim);
    assign state_chg = (nxt != state);

    // Next-state logic, first matching rule wins
    always_comb begin
        nxt = state;
        if (buzz) begin
            nxt = COLL;
        end else begin
            case (state)
                IDLE: begin
                    if (batt_low)      nxt = BATT_ON;
                    else if (fan_pend) nxt = FAN1;
                end
                COLL:     nxt = IDLE;
                BATT_ON:  if (!batt_low) nxt = IDLE; else if (dur_end) nxt = BATT_OFF;
                BATT_OFF: if (!batt_low) nxt = IDLE; else if (dur_end) nxt = BATT_ON;
                FAN1:     if (batt_low) nxt = BATT_ON; else if (dur_end) nxt = FAN2;
                FAN2:     if (batt_low) nxt = BATT_ON; else if (dur_end) nxt = FAN3;
                FAN3:     if (batt_low) nxt = BATT_ON; else if (dur_end) nxt = IDLE;
                default:  nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Duration timer, cleared on every state change
    always_ff @(posedge clk) begin
        if (!rst_n)         dur_cnt <= '0;
        else if (state_chg) dur_cnt <= '0;
        else                dur_cnt <= dur_cnt + DUR_W'(1);
    end

    // Single-entry fanfare latch; requests during playback are dropped
    always_ff @(posedge clk) begin
        if (!rst_n)                                fan_pend <= 1'b0;
        else if (nxt == FAN1 && state != FAN1)     fan_pend <= 1'b0;
        else if (fanfare_req && !in_fan)           fan_pend <= 1'b1;
    end

    piezo_tone u_tone (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (state_chg),
        .en       (tone_active),
        .half_per (half_per),
        .sq       (sq)
    );

    assign piezo   = tone_active & sq;
    assign piezo_n = tone_active & ~sq;
    assign busy    = (state != IDLE);
    assign src     = src_e;

endmodule

// File: tb/tb_piezo_arb.sv
// Directed self-checking bench for piezo_arb with FAST_SIM durations.
module tb_piezo_arb;
    import piezo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       buzz;
    logic       batt_low;
    logic       fanfare_req;
    logic       piezo;
    logic       piezo_n;
    logic       busy;
    logic [1:0] src;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    piezo_arb #(.FAST_SIM(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .buzz        (buzz),
        .batt_low    (batt_low),
        .fanfare_req (fanfare_req),
        .piezo       (piezo),
        .piezo_n     (piezo_n),
        .busy        (busy),
        .src         (src)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; buzz = 1'b0; batt_low = 1'b0; fanfare_req = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({piezo, piezo_n, busy, src} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got piezo/pn/busy/src=%b exp 00000", {piezo, piezo_n, busy, src});
        end
        n_tests++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d exp IDLE", dut.state);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b src=%0d exp 0/0", busy, src);
        end
    endtask

    task automatic test_fanfare();
        int bad; int fk; logic [4:0] fobs; state_t exp_st;
        fanfare_req = 1'b1; tick(); fanfare_req = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fanfare_pending_idle: got busy=%b exp 0", busy);
        end
        tick();
        bad = 0; fk = 0; fobs = '0;
        for (int k = 0; k < 12288; k++) begin
            if (k < 4096)      exp_st = FAN1;
            else if (k < 8192) exp_st = FAN2;
            else               exp_st = FAN3;
            // every note's half-period exceeds 4096, so piezo stays high throughout
            if (piezo !== 1'b1 || piezo_n !== 1'b0 || src !== 2'd3 || busy !== 1'b1 || dut.state !== exp_st) begin
                if (bad == 0) begin fk = k; fobs = {piezo, piezo_n, busy, src}; end
                bad++;
            end
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL fanfare_notes: %0d bad cycles, first at %0d got piezo/pn/busy/src=%b exp 10111", bad, fk, fobs);
        end
        n_tests++;
        if ({piezo, piezo_n, busy, src} !== 5'b0) begin
            n_fail++;
            $display("FAIL fanfare_end_idle: got piezo/pn/busy/src=%b exp 00000", {piezo, piezo_n, busy, src});
        end
    endtask

    task automatic test_collision();
        int bad; int fk; logic [4:0] fobs; logic exp_p;
        buzz = 1'b1; tick();
        bad = 0; fk = 0; fobs = '0;
        for (int k = 0; k < 26000; k++) begin
            exp_p = ((k / 12500) % 2) == 0;
            if (piezo !== exp_p || piezo_n !== ~exp_p || src !== 2'd1 || busy !== 1'b1) begin
                if (bad == 0) begin fk = k; fobs = {piezo, piezo_n, busy, src}; end
                bad++;
            end
            if (k < 25999) tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL coll_tone: %0d bad cycles, first at %0d got piezo/pn/busy/src=%b", bad, fk, fobs);
        end
        buzz = 1'b0; tick();
        n_tests++;
        if ({piezo, piezo_n, busy, src} !== 5'b0) begin
            n_fail++;
            $display("FAIL coll_release: got piezo/pn/busy/src=%b exp 00000", {piezo, piezo_n, busy, src});
        end
    endtask

    task automatic test_battery();
        int bad; int fk; logic [4:0] fobs; logic exp_on;
        batt_low = 1'b1; tick();
        bad = 0; fk = 0; fobs = '0;
        for (int k = 0; k < 12388; k++) begin
            exp_on = (k % 10240) < 2048;
            if (piezo !== exp_on || piezo_n !== 1'b0 || src !== 2'd2 || busy !== 1'b1) begin
                if (bad == 0) begin fk = k; fobs = {piezo, piezo_n, busy, src}; end
                bad++;
            end
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL batt_chirp: %0d bad cycles, first at %0d got piezo/pn/busy/src=%b", bad, fk, fobs);
        end
        n_tests++;
        if (dut.state !== BATT_OFF) begin
            n_fail++;
            $display("FAIL batt_in_off: got state %0d exp BATT_OFF", dut.state);
        end
        batt_low = 1'b0; tick();
        n_tests++;
        if ({piezo, piezo_n, busy, src} !== 5'b0) begin
            n_fail++;
            $display("FAIL batt_release: got piezo/pn/busy/src=%b exp 00000", {piezo, piezo_n, busy, src});
        end
    endtask

    task automatic test_preempt();
        int bad;
        fanfare_req = 1'b1; tick(); fanfare_req = 1'b0;
        tick();
        repeat (4096 + 50) tick();
        n_tests++;
        if (dut.state !== FAN2) begin
            n_fail++;
            $display("FAIL preempt_in_fan2: got state %0d exp FAN2", dut.state);
        end
        buzz = 1'b1; tick();
        n_tests++;
        if (dut.state !== COLL || src !== 2'd1 || piezo !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_coll: got state=%0d src=%0d piezo=%b exp COLL/1/1", dut.state, src, piezo);
        end
        repeat (9) tick();
        buzz = 1'b0; tick();
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (busy !== 1'b0 || src !== 2'd0) bad++;
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL preempt_no_resume: %0d busy cycles after buzz drop exp 0", bad);
        end
    endtask

    task automatic test_starve();
        int bad;
        batt_low = 1'b1; tick();
        fanfare_req = 1'b1; tick(); fanfare_req = 1'b0;
        bad = 0;
        for (int k = 0; k < 3000; k++) begin
            if (src !== 2'd2 || busy !== 1'b1) bad++;
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL starve_batt_holds: %0d cycles not battery exp 0", bad);
        end
        batt_low = 1'b0; tick();
        n_tests++;
        if (busy !== 1'b0 || src !== 2'd0) begin
            n_fail++;
            $display("FAIL starve_idle_gap: got busy=%b src=%0d exp 0/0", busy, src);
        end
        tick();
        n_tests++;
        if (dut.state !== FAN1 || src !== 2'd3 || piezo !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_fan1: got state=%0d src=%0d piezo=%b exp FAN1/3/1", dut.state, src, piezo);
        end
        repeat (10) tick();
        fanfare_req = 1'b1; tick(); fanfare_req = 1'b0;
        repeat (12288 - 11) tick();
        n_tests++;
        if (busy !== 1'b0 || src !== 2'd0) begin
            n_fail++;
            $display("FAIL starve_fan_end: got busy=%b src=%0d exp 0/0", busy, src);
        end
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (busy !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL starve_no_second: %0d busy cycles exp 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        buzz = 1'b1; tick(); tick();
        fanfare_req = 1'b1; tick(); fanfare_req = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (piezo !== 1'b1 || src !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got piezo=%b src=%0d exp 1/1", piezo, src);
        end
        rst_n = 1'b0; tick();
        n_tests++;
        if ({piezo, piezo_n, busy, src} !== 5'b0 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL rstmid_silence: got piezo/pn/busy/src=%b state=%0d exp 00000/IDLE", {piezo, piezo_n, busy, src}, dut.state);
        end
        rst_n = 1'b1; buzz = 1'b0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rstmid_pend_cleared: %0d busy cycles exp 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_fanfare();
        test_collision();
        test_battery();
        test_preempt();
        test_starve();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
